// File: rtl/repetition_tx.sv
// Repetition-code transmitter: serializes one WIDTH-bit word LSB-first, COPIES times back-to-back.
// Optional feature macro REP_PARITY_EN appends an even-parity bit to every copy.
module repetition_tx #(
    parameter int WIDTH  = 15,
    parameter int COPIES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             tx_bit,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_first,
    output logic [2:0]       copy_idx,
    output logic             done
);

`ifdef REP_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int BW = (FRAME > 1) ? $clog2(FRAME) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]         copy_q, copy_d;
    logic               done_q, done_d;
    logic [FRAME-1:0]   frame;
    logic               last_bit, last_copy;

`ifdef REP_PARITY_EN
    assign frame = {^shadow_q, shadow_q};
`else
    assign frame = shadow_q;
`endif

    assign last_bit  = (bit_cnt_q == BW'(FRAME - 1));
    assign last_copy = (copy_q == 3'(COPIES - 1));

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        bit_cnt_d = bit_cnt_q;
        copy_d    = copy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    shadow_d  = din;
                    bit_cnt_d = '0;
                    copy_d    = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (!last_bit) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        bit_cnt_d = '0;
                        // Copy counter parks at its terminal value when the word completes.
                        if (!last_copy) begin
                            copy_d = copy_q + 3'd1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            copy_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            bit_cnt_q <= bit_cnt_d;
            copy_q    <= copy_d;
            done_q    <= done_d;
        end
    end

    // All outputs decode registered state only; nothing flows through from inputs.
    assign din_ready = (state_q == IDLE);
    assign tx_valid  = (state_q == SEND);
    assign tx_bit    = tx_valid & frame[bit_cnt_q];
    assign tx_first  = tx_valid && (bit_cnt_q == '0);
    assign copy_idx  = copy_q;
    assign done      = done_q;

endmodule

// File: doc/repetition_tx.md
# repetition_tx

Transmit-side partner of the bitwise majority voter. Accepts a 15-bit word over a valid/ready handshake and serializes it LSB-first onto a one-bit link, sending the same frame COPIES times back-to-back. The receive end recovers the word by majority vote across the copies. The block sits between the word source and the link driver; link-side flow control is through tx_ready.

## Interface
- WIDTH, 15: data bits per word.
- COPIES, 4: number of times each word is transmitted; legal range 2..8.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  word to transmit; sampled only on acceptance.
- din_valid  input  1  source has a word on din.
- din_ready  output  1  block can accept a word; high only in IDLE.
- tx_bit  output  1  current serial bit.
- tx_valid  output  1  tx_bit is meaningful.
- tx_ready  input  1  link consumes tx_bit this cycle.
- tx_first  output  1  tx_bit is bit 0 of a copy (frame delimiter).
- copy_idx  output  3  index of the copy being sent, 0..COPIES-1.
- done  output  1  one-cycle pulse when the final bit of the final copy is consumed.

## Operation
- FRAME = WIDTH, or WIDTH+1 with REP_PARITY_EN.
- States:
  - IDLE: din_ready=1, tx_valid=0. When din_valid&din_ready: latch din into a shadow register, clear the bit counter and copy counter, go to SEND.
  - SEND: tx_valid=1, tx_bit=frame[bit_cnt]. On each tx_valid&tx_ready:
    - If bit_cnt<FRAME-1: bit_cnt+1.
    - Else bit_cnt=0. If copy_idx<COPIES-1: copy_idx+1. Otherwise go to IDLE and pulse done.
- Bit order is LSB-first. Every copy is identical and drawn from the shadow register. din changes after acceptance have no effect.
- tx_ready low holds tx_bit, tx_first, copy_idx and the counters stable. No bit is skipped or repeated.
- tx_first = (state==SEND && bit_cnt==0).
- Counters are sized for FRAME and COPIES. Neither counter ever wraps past its terminal value.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from din, din_valid or tx_ready to any output.
- Reset values (asynchronous, effective immediately): state=IDLE, din_ready=1, tx_valid=0, tx_bit=0, tx_first=0, copy_idx=0, done=0, shadow register=0.
- Acceptance at edge E0 puts bit 0 of copy 0 on the link in the cycle after E0.
- With tx_ready held high, copy k bit i is presented in cycle E0+1+k*FRAME+i. The last bit is at E0+COPIES*FRAME.
- done is high in the cycle after the last bit is consumed. din_ready is high in that same cycle.
- Back-to-back words: a word accepted in the done cycle starts one cycle later. The minimum gap between words is 1 idle cycle.
- din_valid asserted during SEND is ignored, and din is not captured. The source holds din and din_valid until it sees din_ready.
- rst_n deasserting mid-frame aborts the transfer. No done pulse is produced, and the partial frame is not resumed.

## Configuration
- REP_PARITY_EN defined: each copy is followed by one even-parity bit (XOR of the WIDTH data bits) at bit position WIDTH, so FRAME=WIDTH+1. This lets the receiver discard copies with parity errors before voting.
- REP_PARITY_EN undefined: FRAME=WIDTH and no parity bit is sent. All timing above applies with this smaller FRAME.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with din_valid=1. Required: din_ready=1, tx_valid=0, done=0, and no capture.
- Basic word: din=15'h2AAB, tx_ready=1, no parity, COPIES=4.
  - Link carries 60 bits: the pattern 1,1,0,1,0,1,0,1,0,1,0,1,0,1,0 four times.
  - tx_first is high at offsets 0, 15, 30 and 45; copy_idx steps 0→3.
  - done is high at cycle E0+61.
- Stall: same word, tx_ready=0 for 5 cycles at copy 1 bit 7. Required: tx_bit and copy_idx hold, the full bit sequence is unchanged, and done is delayed by exactly 5 cycles.
- Parity: REP_PARITY_EN defined, din=15'h0007. Required: 16-bit frames with bit 15 = 1; four copies; done at E0+65.
- Back-to-back and ignore-during-send:
  - Send 15'h7FFF, then assert din=15'h0001 in the done cycle; the second word's first bit follows one cycle later.
  - din toggling mid-SEND never alters the transmitted copies.
- Reset mid-operation: assert rst_n=0 at copy 2 bit 4. Required: tx_valid=0 immediately, no done pulse, din_ready=1 after release, and a new word is sent cleanly from copy 0.
